// File: rtl/icache_line_fill_if.sv
// Bundle of signals between the refill engine, the instruction cache and main memory.
// The slave modport is the engine's view. The master modport is the view of the
// surrounding environment: the cache and the memory port.
interface icache_line_fill_if;
  // Cache-side miss request
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         abort;
  logic         busy;
  // Word-wide memory read port
  logic         mem_rd;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  // Early critical word and completed line
  logic         crit_valid;
  logic [31:0]  crit_word;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [127:0] dline;

  modport master (
    output miss_req, miss_addr, abort, mem_ready, mem_rdata,
    input  busy, mem_rd, mem_addr, crit_valid, crit_word, fill_valid, fill_addr, dline
  );

  modport slave (
    input  miss_req, miss_addr, abort, mem_ready, mem_rdata,
    output busy, mem_rd, mem_addr, crit_valid, crit_word, fill_valid, fill_addr, dline
  );
endinterface

// File: rtl/icache_line_fill.sv
// I-cache line refill engine. It fetches the four words of a 128-bit line
// critical word first. The critical word is forwarded early, and the assembled
// line is presented for a single-cycle write into the cache.
module icache_line_fill #(
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  icache_line_fill_if.slave bus
);

  localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t       state_reg;
  logic [27:0]  base_reg;        // line base address bits [31:4]
  logic [1:0]   idx_reg;         // lane that the next captured word is written to
  logic [1:0]   cnt_reg;         // number of words already captured
  logic         abort_pend_reg;  // a redirect was seen while a read was in flight

  logic         busy_reg;
  logic         mem_rd_reg;
  logic [31:0]  mem_addr_reg;
  logic         crit_valid_reg;
  logic [31:0]  crit_word_reg;
  logic         fill_valid_reg;
  logic [31:0]  fill_addr_reg;
  logic [127:0] dline_reg;

  logic [1:0]   idx_inc;
  logic         aborting;

  // The word order wraps from lane 3 back to lane 0.
  assign idx_inc  = idx_reg + 2'd1;
  // A redirect in the same cycle as a handshake takes effect after that handshake.
  assign aborting = bus.abort | abort_pend_reg;

  // Refill state machine. Every output is a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      base_reg       <= '0;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      abort_pend_reg <= 1'b0;
      busy_reg       <= 1'b0;
      mem_rd_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      crit_valid_reg <= 1'b0;
      crit_word_reg  <= '0;
      fill_valid_reg <= 1'b0;
      fill_addr_reg  <= '0;
      dline_reg      <= '0;
    end else begin
      crit_valid_reg <= 1'b0;
      fill_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.miss_req) begin
            base_reg       <= bus.miss_addr[31:4];
            idx_reg        <= bus.miss_addr[3:2];
            cnt_reg        <= '0;
            abort_pend_reg <= 1'b0;
            busy_reg       <= 1'b1;
            mem_rd_reg     <= 1'b1;
            mem_addr_reg   <= {bus.miss_addr[31:2], 2'b00};
            state_reg      <= FETCH;
          end
        end
        FETCH: begin
          if (bus.mem_ready) begin
            dline_reg[{idx_reg, 5'b0} +: 32] <= bus.mem_rdata;
            idx_reg      <= idx_inc;
            cnt_reg      <= cnt_reg + 2'd1;
            mem_addr_reg <= {base_reg, idx_inc, 2'b00};
            if (cnt_reg == 2'd0 && !aborting) begin
              crit_valid_reg <= 1'b1;
              crit_word_reg  <= bus.mem_rdata;
            end
            if (aborting) begin
              // The outstanding read has returned, so the fill can be dropped.
              abort_pend_reg <= 1'b0;
              busy_reg       <= 1'b0;
              mem_rd_reg     <= 1'b0;
              state_reg      <= IDLE;
            end else if (cnt_reg == LAST_WORD) begin
              mem_rd_reg     <= 1'b0;
              fill_valid_reg <= 1'b1;
              fill_addr_reg  <= {base_reg, 4'b0};
              state_reg      <= DONE;
            end
          end else if (bus.abort) begin
            abort_pend_reg <= 1'b1;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.mem_rd     = mem_rd_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.crit_valid = crit_valid_reg;
  assign bus.crit_word  = crit_word_reg;
  assign bus.fill_valid = fill_valid_reg;
  assign bus.fill_addr  = fill_addr_reg;
  assign bus.dline      = dline_reg;

endmodule
